slave_capture_fifo: RTL and testbench

SLAVE_CAPTURE_FIFO -- requirements
Module: slave_capture_fifo

---
 rtl/slave_capture_fifo_if.sv | 24 ++
 rtl/slave_capture_fifo.sv | 156 +++++++++++++++
 tb/tb_slave_capture_fifo.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_capture_fifo_if.sv
// Bus-side signal bundle for the slave capture FIFO: sensed vector, shared
// address bus, read strobe and capture-ready flag.
interface slave_capture_fifo_if #(
  parameter int SIG_W = 64
);
  logic [SIG_W-1:0] Lsignalin;
  logic [7:0]       address;
  logic             cs;
  logic             enwipeout;

  modport master (
    output Lsignalin,
    output address,
    input  cs,
    input  enwipeout
  );

  modport slave (
    input  Lsignalin,
    input  address,
    output cs,
    output enwipeout
  );
endinterface

// File: rtl/slave_capture_fifo.sv
// Change-detecting snapshot capture into a small FIFO, read back over a shared
// 8-bit address bus with a registered byte port and edge-triggered pop.
module slave_capture_fifo #(
  parameter int SIG_W   = 64,
  parameter int THRESH  = 4,
  parameter int CHIP_ID = 0,
  parameter int DEPTH   = 4
) (
  input  logic                 clkin,
  input  logic                 rst,
  slave_capture_fifo_if.slave  bus,
  output logic [7:0]           dataout
);

  localparam int BYTES = SIG_W / 8;
  localparam int PCW   = $clog2(SIG_W + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int EW    = SIG_W + 16;

  localparam logic [PCW-1:0] THRESH_C = PCW'(THRESH);
  localparam logic [2:0]     CHIP_C   = 3'(CHIP_ID);
  localparam logic [7:0]     POP_ADDR = {CHIP_C, 5'h1E};
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);

  logic [SIG_W-1:0] refVal_q, refVal_d;
  logic [15:0]      ts_q;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       data_q, data_d;
  logic             cs_q;
  logic [7:0]       prevAddr_q;

  logic [PCW-1:0]   popCnt;
  logic             capture;
  logic             select;
  logic             flush;
  logic             popEdge;
  logic             doPop;
  logic             doPush;
  logic             full;
  logic             empty;
  logic [EW-1:0]    head;
  logic [7:0]       rdByte;

  // Number of bits that moved away from the last captured snapshot.
  always_comb begin
    popCnt = '0;
    for (int i = 0; i < SIG_W; i++) begin
      popCnt = popCnt + PCW'(bus.Lsignalin[i] ^ refVal_q[i]);
    end
  end

  // A pop may ride along with a push into a full FIFO, so push qualifies on it.
  always_comb begin
    full    = (count_q == DEPTH_C);
    empty   = (count_q == '0);
    flush   = (bus.address == 8'hFF);
    select  = (bus.address[7:5] == CHIP_C) && !flush;
    capture = (popCnt > THRESH_C) && !(&bus.Lsignalin);
    popEdge = (bus.address == POP_ADDR) && (prevAddr_q != bus.address);
    doPop   = popEdge && !empty;
    doPush  = capture && (!full || doPop);
  end

  always_comb begin
    refVal_d = refVal_q;
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      refVal_d = '0;
      wrPtr_d  = '0;
      rdPtr_d  = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (doPush) begin
        refVal_d = bus.Lsignalin;
        wrPtr_d  = wrPtr_q + 1'b1;
      end else if (capture) begin
        ovf_d = 1'b1;
      end
      if (doPop) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Snapshot bytes and head timestamp read as zero whenever nothing is queued.
  always_comb begin
    head   = mem_q[rdPtr_q];
    rdByte = 8'h00;
    if (bus.address[4:0] == 5'h1A) begin
      rdByte = {ovf_q, empty, full, 1'b0, 4'(count_q)};
    end else if (!empty) begin
      if (bus.address[4:0] == 5'h18) begin
        rdByte = head[7:0];
      end else if (bus.address[4:0] == 5'h19) begin
        rdByte = head[15:8];
      end else begin
        for (int k = 0; k < BYTES; k++) begin
          if (bus.address[4:0] == 5'(k)) begin
            rdByte = head[16 + 8*k +: 8];
          end
        end
      end
    end
    data_d = select ? rdByte : data_q;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      refVal_q   <= '0;
      ts_q       <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      data_q     <= 8'h00;
      cs_q       <= 1'b0;
      prevAddr_q <= 8'hFF;
    end else begin
      refVal_q   <= refVal_d;
      ts_q       <= ts_q + 16'd1;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      data_q     <= data_d;
      cs_q       <= select;
      prevAddr_q <= bus.address;
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clkin) begin
    if (doPush && !flush) begin
      mem_q[wrPtr_q] <= {bus.Lsignalin, ts_q};
    end
  end

  assign bus.cs        = cs_q;
  assign bus.enwipeout = !full;
  assign dataout       = select ? data_q : 8'bz;

endmodule

// File: tb/tb_slave_capture_fifo.sv
// Scoreboard bench for slave_capture_fifo: a cycle model queues expected
// snapshots on capture and the bus reads compare them against the DUT.
module tb_slave_capture_fifo;

  localparam int         THRESH = 4;
  localparam int         DEPTH  = 4;
  localparam logic [2:0] CHIP   = 3'd0;
  localparam logic [7:0] IDLE   = 8'h20;
  localparam logic [7:0] POPA   = {CHIP, 5'h1E};

  logic        clkin = 1'b0;
  logic        rst   = 1'b0;
  wire  [7:0]  dataout;

  slave_capture_fifo_if #(.SIG_W(64)) bus ();

  slave_capture_fifo #(
    .SIG_W(64), .THRESH(THRESH), .CHIP_ID(0), .DEPTH(DEPTH)
  ) dut (
    .clkin(clkin), .rst(rst), .bus(bus), .dataout(dataout)
  );

  always #5 clkin = ~clkin;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] mRef;
  logic        mOvf;
  logic [7:0]  mPrev;
  logic [15:0] tsModel;
  logic [63:0] curSig;
  logic [79:0] expQ [$];

  always @(posedge clkin or posedge rst) begin
    if (rst) tsModel <= 16'h0000;
    else     tsModel <= tsModel + 16'h0001;
  end

  task automatic modelReset();
    expQ.delete();
    mRef  = '0;
    mOvf  = 1'b0;
    mPrev = 8'hFF;
  endtask

  // Drive one cycle of inputs and advance the reference model across the edge.
  task automatic stepCycle(input logic [63:0] sig, input logic [7:0] addr);
    logic cap, fl, popE, full, doPop, doPush;
    logic [79:0] entry;
    @(negedge clkin);
    bus.Lsignalin = sig;
    bus.address   = addr;
    curSig        = sig;
    cap    = ($countones(sig ^ mRef) > THRESH) && (sig != {64{1'b1}});
    fl     = (addr == 8'hFF);
    popE   = (addr == POPA) && (addr != mPrev);
    full   = (expQ.size() == DEPTH);
    doPop  = popE && (expQ.size() > 0);
    doPush = cap && (!full || doPop);
    entry  = {sig, tsModel};
    @(posedge clkin);
    if (fl) begin
      expQ.delete();
      mOvf = 1'b0;
      mRef = '0;
    end else begin
      if (doPop) void'(expQ.pop_front());
      if (doPush) begin
        expQ.push_back(entry);
        mRef = sig;
      end else if (cap) begin
        mOvf = 1'b1;
      end
    end
    mPrev = addr;
    #1;
  endtask

  task automatic readAt(input logic [7:0] addr);
    stepCycle(curSig, addr);
  endtask

  function automatic logic [7:0] expStatus();
    int n;
    n = expQ.size();
    return {mOvf, n == 0, n == DEPTH, 1'b0, 4'(n)};
  endfunction

  function automatic logic [7:0] expRead(input logic [7:0] a);
    logic [79:0] h;
    logic [4:0]  idx;
    idx = a[4:0];
    if (idx == 5'h1A) return expStatus();
    if (expQ.size() == 0) return 8'h00;
    h = expQ[0];
    if (idx < 5'd8)    return h[16 + 8*idx +: 8];
    if (idx == 5'h18)  return h[7:0];
    if (idx == 5'h19)  return h[15:8];
    return 8'h00;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.Lsignalin = '0;
    bus.address   = 8'h00;
    curSig        = '0;
    repeat (3) @(posedge clkin);
    #1;
    checks++;
    if (bus.cs !== 1'b0 || bus.enwipeout !== 1'b1 || dataout !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: cs=%b enwipeout=%b dataout=%h, expected cs=0 enwipeout=1 dataout=00",
               bus.cs, bus.enwipeout, dataout);
    end
    @(negedge clkin);
    rst = 1'b0;
    modelReset();
    readAt(8'h1A);
    checks++;
    if (dataout !== 8'h40 || bus.cs !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_status: dataout=%h cs=%b, expected 40 cs=1", dataout, bus.cs);
    end
  endtask

  task automatic test_readback();
    int guard;
    logic [7:0] exp;
    stepCycle('0, 8'hFF);
    guard = 0;
    while (tsModel != 16'h0123 && guard < 1000) begin
      stepCycle('0, IDLE);
      guard++;
    end
    checks++;
    if (guard >= 1000) begin
      errors++;
      $display("[TB] FAIL rb_ts_wait: ts=%h, expected to reach 0123", tsModel);
    end
    stepCycle(64'h8877_6655_4433_2211, IDLE);
    readAt(8'h00);
    checks++;
    if (dataout !== 8'h11 || bus.cs !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rb_byte0: dataout=%h cs=%b, expected 11 cs=1", dataout, bus.cs);
    end
    for (int k = 1; k < 7; k++) begin
      readAt(8'(k));
      exp = expRead(8'(k));
      checks++;
      if (dataout !== exp) begin
        errors++;
        $display("[TB] FAIL rb_byte%0d: dataout=%h, expected %h", k, dataout, exp);
      end
    end
    readAt(8'h07);
    checks++;
    if (dataout !== 8'h88) begin
      errors++;
      $display("[TB] FAIL rb_byte7: dataout=%h, expected 88", dataout);
    end
    readAt(8'h18);
    checks++;
    if (dataout !== 8'h23) begin
      errors++;
      $display("[TB] FAIL rb_ts_low: dataout=%h, expected 23", dataout);
    end
    readAt(8'h19);
    checks++;
    if (dataout !== 8'h01) begin
      errors++;
      $display("[TB] FAIL rb_ts_high: dataout=%h, expected 01", dataout);
    end
    readAt(IDLE);
    checks++;
    if (!(dataout === 8'hzz || dataout === 8'h00) || bus.cs !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rb_unselected: dataout=%h cs=%b, expected zz (00 in 2-state) cs=0", dataout, bus.cs);
    end
    readAt(POPA);
    readAt(8'h00);
    checks++;
    if (dataout !== 8'h00 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL rb_empty_byte: dataout=%h, expected 00", dataout);
    end
    readAt(8'h18);
    checks++;
    if (dataout !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rb_empty_ts: dataout=%h, expected 00", dataout);
    end
  endtask

  task automatic test_threshold();
    stepCycle('0, 8'hFF);
    stepCycle(64'h1F, IDLE);
    readAt(8'h1A);
    checks++;
    if (dataout !== 8'h01 || dataout !== expStatus()) begin
      errors++;
      $display("[TB] FAIL thr_push: status=%h, expected 01", dataout);
    end
    readAt(8'h00);
    checks++;
    if (dataout !== 8'h1F) begin
      errors++;
      $display("[TB] FAIL thr_head: dataout=%h, expected 1f", dataout);
    end
    stepCycle(64'h0F, IDLE);
    stepCycle(64'hF1F, IDLE);
    readAt(8'h1A);
    checks++;
    if (dataout !== 8'h01) begin
      errors++;
      $display("[TB] FAIL thr_no_push: status=%h, expected 01", dataout);
    end
    stepCycle(64'h1F1F, IDLE);
    readAt(8'h1A);
    checks++;
    if (dataout !== 8'h02 || dataout !== expStatus()) begin
      errors++;
      $display("[TB] FAIL thr_above: status=%h, expected 02", dataout);
    end
  endtask

  task automatic test_all_ones();
    stepCycle('0, 8'hFF);
    stepCycle({64{1'b1}}, IDLE);
    readAt(8'h1A);
    checks++;
    if (dataout !== 8'h40 || bus.enwipeout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL all_ones: status=%h enwipeout=%b, expected 40 enwipeout=1", dataout, bus.enwipeout);
    end
  endtask

  task automatic test_overflow();
    stepCycle('0, 8'hFF);
    for (int k = 0; k <= DEPTH; k++) stepCycle(64'hFF << (8*k), IDLE);
    stepCycle(64'hFF << 24, IDLE);
    checks++;
    if (bus.enwipeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_enwipe: enwipeout=%b, expected 0", bus.enwipeout);
    end
    readAt(8'h1A);
    checks++;
    if (dataout !== 8'hA4 || dataout !== expStatus()) begin
      errors++;
      $display("[TB] FAIL ovf_status: status=%h, expected a4", dataout);
    end
    repeat (3) stepCycle(curSig, POPA);
    checks++;
    if (bus.enwipeout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pop_enwipe: enwipeout=%b, expected 1", bus.enwipeout);
    end
    readAt(8'h1A);
    checks++;
    if (dataout !== 8'h83 || dataout !== expStatus()) begin
      errors++;
      $display("[TB] FAIL pop_status: status=%h, expected 83", dataout);
    end
    readAt(8'h01);
    checks++;
    if (dataout !== 8'hFF || dataout !== expRead(8'h01)) begin
      errors++;
      $display("[TB] FAIL pop_head: dataout=%h, expected ff", dataout);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    logic [7:0] a;
    stepCycle(64'hFF << 40, IDLE);
    stepCycle(64'hFF << 48, POPA);
    checks++;
    if (bus.enwipeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_full: enwipeout=%b, expected 0", bus.enwipeout);
    end
    readAt(8'h1A);
    checks++;
    if (dataout !== 8'hA4) begin
      errors++;
      $display("[TB] FAIL b2b_status: status=%h, expected a4", dataout);
    end
    for (int n = 0; n < 2 * DEPTH && expQ.size() > 0; n++) begin
      for (int k = 0; k < 10; k++) begin
        a = (k < 8) ? 8'(k) : 8'(8'h18 + k - 8);
        readAt(a);
        exp = expRead(a);
        checks++;
        if (dataout !== exp) begin
          errors++;
          $display("[TB] FAIL drain_%0d_%h: dataout=%h, expected %h", n, a, dataout, exp);
        end
      end
      stepCycle(curSig, POPA);
      stepCycle(curSig, IDLE);
    end
    readAt(8'h1A);
    checks++;
    if (dataout !== 8'hC0) begin
      errors++;
      $display("[TB] FAIL drain_status: status=%h, expected c0", dataout);
    end
    stepCycle(curSig, POPA);
    stepCycle(curSig, IDLE);
    readAt(8'h1A);
    checks++;
    if (dataout !== 8'hC0) begin
      errors++;
      $display("[TB] FAIL pop_empty: status=%h, expected c0", dataout);
    end
  endtask

  task automatic test_flush_push();
    stepCycle(64'h1F, IDLE);
    stepCycle(64'h0F0F_3C3C, 8'hFF);
    readAt(8'h1A);
    checks++;
    if (dataout !== 8'h40) begin
      errors++;
      $display("[TB] FAIL flush_status: status=%h, expected 40", dataout);
    end
    readAt(8'h1A);
    checks++;
    if (dataout !== 8'h01 || dataout !== expStatus()) begin
      errors++;
      $display("[TB] FAIL flush_ref_zero: status=%h, expected 01", dataout);
    end
    readAt(8'h00);
    checks++;
    if (dataout !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL flush_head: dataout=%h, expected 3c", dataout);
    end
  endtask

  task automatic test_async_reset();
    stepCycle(64'hFF << 32, IDLE);
    stepCycle(64'hFF << 40, IDLE);
    stepCycle(64'hFF << 48, IDLE);
    checks++;
    if (bus.enwipeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ar_prefull: enwipeout=%b, expected 0", bus.enwipeout);
    end
    @(negedge clkin);
    bus.address = IDLE;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.enwipeout !== 1'b1 || bus.cs !== 1'b0 || !(dataout === 8'hzz || dataout === 8'h00)) begin
      errors++;
      $display("[TB] FAIL ar_async: enwipeout=%b cs=%b dataout=%h, expected 1 0 zz", bus.enwipeout, bus.cs, dataout);
    end
    bus.address = 8'h00;
    #1;
    checks++;
    if (dataout !== 8'h00) begin
      errors++;
      $display("[TB] FAIL ar_selected: dataout=%h, expected 00", dataout);
    end
    modelReset();
    @(posedge clkin);
    #2 rst = 1'b0;
    stepCycle(64'h1F, IDLE);
    readAt(8'h1A);
    checks++;
    if (dataout !== 8'h01) begin
      errors++;
      $display("[TB] FAIL ar_first_capture: status=%h, expected 01", dataout);
    end
    readAt(8'h18);
    checks++;
    if (dataout !== 8'h00 || dataout !== expRead(8'h18)) begin
      errors++;
      $display("[TB] FAIL ar_ts: dataout=%h, expected 00", dataout);
    end
    readAt(8'h00);
    checks++;
    if (dataout !== 8'h1F) begin
      errors++;
      $display("[TB] FAIL ar_head: dataout=%h, expected 1f", dataout);
    end
  endtask

  initial begin
    test_reset();
    test_readback();
    test_threshold();
    test_all_ones();
    test_overflow();
    test_back_to_back();
    test_flush_push();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
